julia_pixel_scheduler: RTL
==========================

Name: julia_pixel_scheduler

Overview:
- Sequences the Julia-set iteration engine across one full frame once the parameter-entry block asserts `valid`.
- Latches c_real/c_comp/x/y/scale, walks pixels in raster order, and generates each pixel's starting z incrementally (adds only, no multiplier).
- Issues one pixel at a time to the engine over a start/ready handshake, waits for the iteration count, and writes it to the VGA frame buffer.
- Sits between the parameter-entry block, the iteration engine and the frame-buffer write port.

Parameters:
- H_PIX, 640, pixels per row
- V_PIX, 480, rows per frame
- COL_W, 10, column counter width
- ROW_W, 9, row counter width
- ADDR_W, 19, frame-buffer address width
- ITER_W, 8, iteration-count width
- DATA_W, 18, fixed-point width (4.14 two's complement)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cfg_valid  in  1  parameters final (level)
- c_real, c_comp, x, y, scale  in  DATA_W each  frame parameters; x,y = top-left corner; scale = step per pixel
- eng_start  out  1  operands valid to engine
- eng_ready  in  1  engine can accept
- eng_z_real, eng_z_imag, eng_c_real, eng_c_imag  out  DATA_W  engine operands
- eng_done  in  1  one-cycle result strobe
- eng_count  in  ITER_W  iteration count, valid with eng_done
- fb_we  out  1  frame-buffer write request
- fb_busy  in  1  frame buffer stalled (VGA read has priority)
- fb_addr  out  ADDR_W  row*H_PIX+col
- fb_data  out  ITER_W  count to store
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last write

Behaviour:
- Reset (async, reset=0): state=IDLE; all outputs 0; column, row, address and z accumulators cleared; latched parameters cleared.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE, cfg_valid=1:
  - Latch all five parameters; z_real=x, z_imag=y, col=row=addr=0.
  - Go to ISSUE. The first eng_start is high the cycle after cfg_valid is sampled.
- ISSUE:
  - eng_start=1; operands held stable.
  - Transfer occurs in the cycle where eng_start & eng_ready, then go to WAIT. Otherwise stay in ISSUE.
- WAIT:
  - On eng_done: capture eng_count into fb_data, go to WRITE.
  - eng_done in any other state is ignored.
- WRITE:
  - fb_we=1 with fb_addr/fb_data stable; the write is accepted in a cycle with fb_we & !fb_busy.
  - On acceptance, if col≠H_PIX-1: col+1, z_real+=scale, addr+1 → ISSUE.
  - On acceptance, if col=H_PIX-1 and row≠V_PIX-1: col=0, row+1, z_real=x, z_imag-=scale, addr+1 → ISSUE.
  - On acceptance of the last pixel (col=H_PIX-1, row=V_PIX-1): frame_done=1 for exactly one cycle → DONE.
- DONE:
  - busy=0; holds until cfg_valid=0, then goes to IDLE. No restart while cfg_valid stays high.
- busy=1 in ISSUE, WAIT and WRITE.
- Arithmetic: DATA_W two's complement adds/subtracts. Overflow wraps silently, with no saturation. eng_c_real/eng_c_imag are the latched c values.
- Parameter inputs are ignored outside IDLE; a mid-frame change has no effect.
- Minimum per-pixel cost: 1 ISSUE + engine latency + 1 WRITE cycle.
- Reset mid-frame: immediate return to reset values; the in-flight engine result is discarded. The engine shares the same reset.

Optional Feature:
- Macro: JULIA_SCHED_PERF_EN.
- When defined:
  - Adds output frame_cycles (32 bits): counts clocks from leaving IDLE to entering DONE inclusive.
  - Holds its value in DONE; clears on the next IDLE→ISSUE transition and on reset.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package julia_pkg holds:
  - DATA_W, ITER_W, H_PIX, V_PIX;
  - the 4.14 format constants (FRAC_BITS=14);
  - the state encoding typedef for this block.
- One natural sub-module, julia_coord_gen: column/row/address counters plus z accumulators, with inputs load/advance and outputs last_col/last_pix.
- The FSM and handshakes stay in the top level.

Test Plan:
1. Basic raster with H_PIX=4, V_PIX=3, x=0x38000 (−2.0), y=0x08000 (+2.0), scale=0x00100, engine ready with 3-cycle latency → 12 writes, addr 0..11. Pixel (3,0): z_real=0x38300. Pixel (0,1): z_real=0x38000, z_imag=0x07F00. frame_done pulses once.
2. eng_ready=0 for 5 cycles in ISSUE → eng_start held, operands unchanged, no extra transfer.
3. fb_busy=1 for 4 cycles in WRITE → fb_we held, addr/data stable, a single write on release.
4. Spurious eng_done in ISSUE and DONE → no write, no state change.
5. Async reset asserted in WAIT at pixel 5 → all outputs 0 immediately. Reassert cfg_valid → frame restarts at addr 0.
6. cfg_valid held high after DONE → no second frame. Drop cfg_valid then raise it → new frame uses the newly latched parameters.

Source files
------------

// File: rtl/julia_pkg.sv
// Shared constants and state encoding for the Julia-set frame scheduler.
// 4.14 two's complement fixed point throughout.
package julia_pkg;

    localparam int DATA_W    = 18;
    localparam int ITER_W    = 8;
    localparam int H_PIX     = 640;
    localparam int V_PIX     = 480;
    localparam int COL_W     = 10;
    localparam int ROW_W     = 9;
    localparam int ADDR_W    = 19;
    localparam int FRAC_BITS = 14;
    localparam int INT_BITS  = DATA_W - FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/julia_coord_gen.sv
// Raster column/row/address counters with incremental z start points.
// Adds only: z_real steps by scale per column, z_imag steps down per row.
module julia_coord_gen
    import julia_pkg::*;
#(
    parameter int H_PIX  = julia_pkg::H_PIX,
    parameter int V_PIX  = julia_pkg::V_PIX,
    parameter int COL_W  = julia_pkg::COL_W,
    parameter int ROW_W  = julia_pkg::ROW_W,
    parameter int ADDR_W = julia_pkg::ADDR_W,
    parameter int DATA_W = julia_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] scale,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] z_real,
    output logic [DATA_W-1:0] z_imag,
    output logic              last_col,
    output logic              last_pix
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_PIX - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_PIX - 1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] scale_q;

    assign last_col = (col == LAST_COL);
    assign last_pix = last_col && (row == LAST_ROW);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            z_real  <= '0;
            z_imag  <= '0;
            x_q     <= '0;
            scale_q <= '0;
        end else if (load) begin
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            z_real  <= x;
            z_imag  <= y;
            x_q     <= x;
            scale_q <= scale;
        end else if (advance) begin
            addr <= addr + 1'b1;
            if (last_col) begin
                col    <= '0;
                row    <= row + 1'b1;
                z_real <= x_q;
                z_imag <= z_imag - scale_q;
            end else begin
                col    <= col + 1'b1;
                z_real <= z_real + scale_q;
            end
        end
    end

endmodule

// File: rtl/julia_pixel_scheduler.sv
// Walks one frame of pixels through the Julia iteration engine into the frame buffer.
// Optional JULIA_SCHED_PERF_EN adds a frame_cycles counter output.
module julia_pixel_scheduler
    import julia_pkg::*;
#(
    parameter int H_PIX  = julia_pkg::H_PIX,
    parameter int V_PIX  = julia_pkg::V_PIX,
    parameter int COL_W  = julia_pkg::COL_W,
    parameter int ROW_W  = julia_pkg::ROW_W,
    parameter int ADDR_W = julia_pkg::ADDR_W,
    parameter int ITER_W = julia_pkg::ITER_W,
    parameter int DATA_W = julia_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] c_real,
    input  logic [DATA_W-1:0] c_comp,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] scale,
    output logic              eng_start,
    input  logic              eng_ready,
    output logic [DATA_W-1:0] eng_z_real,
    output logic [DATA_W-1:0] eng_z_imag,
    output logic [DATA_W-1:0] eng_c_real,
    output logic [DATA_W-1:0] eng_c_imag,
    input  logic              eng_done,
    input  logic [ITER_W-1:0] eng_count,
    output logic              fb_we,
    input  logic              fb_busy,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [ITER_W-1:0] fb_data,
    output logic              busy,
    output logic              frame_done
`ifdef JULIA_SCHED_PERF_EN
    ,
    output logic [31:0]       frame_cycles
`endif
);

    state_t state;
    state_t state_nx;

    logic load;
    logic advance;
    logic capture;
    logic last_col;
    logic last_pix;
    logic frame_end;

    logic [DATA_W-1:0] c_real_q;
    logic [DATA_W-1:0] c_comp_q;
    logic [ITER_W-1:0] fb_data_q;
    logic              frame_done_q;

    julia_coord_gen #(
        .H_PIX  (H_PIX),
        .V_PIX  (V_PIX),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_coord (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .advance  (advance),
        .x        (x),
        .y        (y),
        .scale    (scale),
        .addr     (fb_addr),
        .z_real   (eng_z_real),
        .z_imag   (eng_z_imag),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        fb_we     = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        capture   = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    load     = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                eng_start = 1'b1;
                if (eng_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (eng_done) begin
                    capture  = 1'b1;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                busy  = 1'b1;
                fb_we = 1'b1;
                if (!fb_busy) begin
                    if (last_col && last_pix) begin
                        frame_end = 1'b1;
                        state_nx  = S_DONE;
                    end else begin
                        advance  = 1'b1;
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (!cfg_valid) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_real_q     <= '0;
            c_comp_q     <= '0;
            fb_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (load) begin
                c_real_q <= c_real;
                c_comp_q <= c_comp;
            end
            if (capture) begin
                fb_data_q <= eng_count;
            end
        end
    end

    assign eng_c_real = c_real_q;
    assign eng_c_imag = c_comp_q;
    assign fb_data    = fb_data_q;
    assign frame_done = frame_done_q;

`ifdef JULIA_SCHED_PERF_EN
    // The leaving-IDLE cycle counts as 1; entering DONE is the last counted.
    logic [31:0] cyc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else if (load) begin
            cyc_q <= 32'd1;
        end else if (busy) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign frame_cycles = cyc_q;
`endif

endmodule
